// File: rtl/axi_read_traffic_gen.sv
// AXI4 read traffic generator: issues a programmable series of INCR AR bursts
// and counts returned R beats, busy cycles and response errors.

typedef struct packed {
   logic [4:0]  id;
   logic [31:0] addr;
   logic [7:0]  len;
   logic [2:0]  size;
   logic [1:0]  burst;
   logic        lock;
   logic [3:0]  cache;
   logic [2:0]  prot;
   logic [3:0]  qos;
   logic [3:0]  region;
   logic [5:0]  atop;
   logic [4:0]  user;
} axi_rtg_aw_chan_t;

typedef struct packed {
   logic [4:0]  id;
   logic [31:0] addr;
   logic [7:0]  len;
   logic [2:0]  size;
   logic [1:0]  burst;
   logic        lock;
   logic [3:0]  cache;
   logic [2:0]  prot;
   logic [3:0]  qos;
   logic [3:0]  region;
   logic [4:0]  user;
} axi_rtg_ar_chan_t;

typedef struct packed {
   logic [511:0] data;
   logic [63:0]  strb;
   logic         last;
   logic [4:0]   user;
} axi_rtg_w_chan_t;

typedef struct packed {
   logic [4:0] id;
   logic [1:0] resp;
   logic [4:0] user;
} axi_rtg_b_chan_t;

typedef struct packed {
   logic [4:0]   id;
   logic [511:0] data;
   logic [1:0]   resp;
   logic         last;
   logic [4:0]   user;
} axi_rtg_r_chan_t;

typedef struct packed {
   axi_rtg_aw_chan_t aw;
   logic             aw_valid;
   axi_rtg_w_chan_t  w;
   logic             w_valid;
   logic             b_ready;
   axi_rtg_ar_chan_t ar;
   logic             ar_valid;
   logic             r_ready;
} axi_rtg_req_t;

typedef struct packed {
   logic             aw_ready;
   logic             ar_ready;
   logic             w_ready;
   logic             b_valid;
   axi_rtg_b_chan_t  b;
   logic             r_valid;
   axi_rtg_r_chan_t  r;
} axi_rtg_resp_t;

module axi_read_traffic_gen #(
   parameter int unsigned AxiAddrWidth   = 32,
   parameter int unsigned AxiDataWidth   = 512,
   parameter int unsigned AxiIdWidth     = 5,
   parameter int unsigned AxiUserWidth   = 5,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned CntWidth       = 32,
   parameter type         axi_req_t      = axi_rtg_req_t,
   parameter type         axi_resp_t     = axi_rtg_resp_t
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [AxiAddrWidth-1:0] base_addr_i,
   input  logic [AxiAddrWidth-1:0] stride_i,
   input  logic [CntWidth-1:0]     num_bursts_i,
   input  logic [7:0]              burst_len_i,
   output axi_req_t                axi_req_o,
   input  axi_resp_t               axi_resp_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [CntWidth-1:0]     beats_o,
   output logic [CntWidth-1:0]     cycles_o,
   output logic                    err_o
);

   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
   localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);
   localparam logic [2:0] AxSize = 3'($clog2(AxiDataWidth / 8));

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e                  state_q, state_d;
   logic [AxiAddrWidth-1:0] addr_q, addr_d;
   logic [AxiAddrWidth-1:0] stride_q, stride_d;
   logic [CntWidth-1:0]     num_q, num_d;
   logic [CntWidth-1:0]     issued_q, issued_d;
   logic [CntWidth-1:0]     beats_q, beats_d;
   logic [CntWidth-1:0]     cycles_q, cycles_d;
   logic [7:0]              len_q, len_d;
   logic [7:0]              beat_q, beat_d;
   logic [OutW-1:0]         out_q, out_d;
   logic                    err_q, err_d;

   logic ar_valid, r_ready, ar_hs, r_hs, r_done;
   logic unused_resp;

   assign unused_resp = ^axi_resp_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         num_q    <= '0;
         issued_q <= '0;
         beats_q  <= '0;
         cycles_q <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         num_q    <= num_d;
         issued_q <= issued_d;
         beats_q  <= beats_d;
         cycles_q <= cycles_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         out_q    <= out_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      num_d    = num_q;
      issued_d = issued_q;
      beats_d  = beats_q;
      cycles_d = cycles_q;
      len_d    = len_q;
      beat_d   = beat_q;
      out_d    = out_q;
      err_d    = err_q;

      if (ar_hs) begin
         addr_d   = addr_q + stride_q;
         issued_d = issued_q + 1'b1;
      end
      // One beat counter suffices because R data returns in AR order.
      if (r_hs) begin
         beats_d = beats_q + 1'b1;
         if (axi_resp_i.r.resp != 2'b00 || axi_resp_i.r.last != (beat_q == len_q)) begin
            err_d = 1'b1;
         end
         beat_d = axi_resp_i.r.last ? 8'd0 : beat_q + 1'b1;
      end
      if (ar_hs && !r_done) begin
         out_d = out_q + 1'b1;
      end else if (!ar_hs && r_done) begin
         out_d = out_q - 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d  = RUN;
               addr_d   = base_addr_i;
               stride_d = stride_i;
               num_d    = num_bursts_i;
               len_d    = burst_len_i;
               issued_d = '0;
               beats_d  = '0;
               cycles_d = '0;
               beat_d   = '0;
               out_d    = '0;
               err_d    = 1'b0;
            end
         end
         RUN: begin
            cycles_d = cycles_q + 1'b1;
            if (issued_q == num_q) begin
               state_d = DONE;
            end else if (ar_hs && issued_d == num_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            cycles_d = cycles_q + 1'b1;
            if (out_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o   = (state_q == RUN) || (state_q == DRAIN);
      done_o   = (state_q == DONE);
      beats_o  = beats_q;
      cycles_o = cycles_q;
      err_o    = err_q;

      ar_valid = (state_q == RUN) && (issued_q != num_q) && (out_q < MaxOut);
      r_ready  = busy_o;
      ar_hs    = ar_valid && axi_resp_i.ar_ready;
      r_hs     = r_ready && axi_resp_i.r_valid;
      r_done   = r_hs && axi_resp_i.r.last && (out_q != '0);

      axi_req_o          = '0;
      axi_req_o.ar.id    = AxiIdWidth'(issued_q);
      axi_req_o.ar.addr  = addr_q;
      axi_req_o.ar.len   = len_q;
      axi_req_o.ar.size  = AxSize;
      axi_req_o.ar.burst = 2'b01;
      axi_req_o.ar_valid = ar_valid;
      axi_req_o.r_ready  = r_ready;
      axi_req_o.b_ready  = 1'b1;
   end

endmodule

// File: tb/tb_axi_read_traffic_gen.sv
// Bench for axi_read_traffic_gen: two instances (MaxOutstanding 8 and 2), each
// driven by a randomized AXI read slave and checked against a burst-level model.

module tb_axi_read_traffic_gen;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 5;
   localparam int UW = 5;
   localparam int CW = 32;
   localparam int SZ = $clog2(DW / 8);

   typedef struct packed {
      logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;
      logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
      logic [3:0] qos; logic [3:0] region; logic [5:0] atop; logic [UW-1:0] user;
   } aw_t;
   typedef struct packed {
      logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;
      logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
      logic [3:0] qos; logic [3:0] region; logic [UW-1:0] user;
   } ar_t;
   typedef struct packed {
      logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; logic [UW-1:0] user;
   } w_t;
   typedef struct packed {
      logic [IW-1:0] id; logic [1:0] resp; logic [UW-1:0] user;
   } b_t;
   typedef struct packed {
      logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic [UW-1:0] user;
   } r_t;
   typedef struct packed {
      aw_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
      ar_t ar; logic ar_valid; logic r_ready;
   } req_t;
   typedef struct packed {
      logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_t b;
      logic r_valid; r_t r;
   } resp_t;
   typedef struct {
      int            n;
      logic [7:0]    len;
      logic [IW-1:0] id;
   } rq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          start  [2];
   logic [AW-1:0] base_a [2];
   logic [AW-1:0] strd_a [2];
   logic [CW-1:0] num_a  [2];
   logic [7:0]    len_a  [2];
   req_t          req    [2];
   resp_t         resp   [2];
   logic          busy   [2];
   logic          done   [2];
   logic          err    [2];
   logic [CW-1:0] beats  [2];
   logic [CW-1:0] cycles [2];

   // Slave behaviour knobs and burst-level model state, per instance.
   logic [AW-1:0] cfg_base [2];
   logic [AW-1:0] cfg_strd [2];
   logic [7:0]    cfg_len  [2];
   int unsigned   ar_pct   [2] = '{100, 100};
   int unsigned   ar_stall [2] = '{0, 0};
   int unsigned   r_pct    [2] = '{100, 100};
   int            err_rb   [2] = '{-1, -1};
   int            err_lb   [2] = '{-1, -1};
   bit            flush    [2] = '{0, 0};
   int unsigned   ar_cnt   [2] = '{0, 0};
   int unsigned   cpl_cnt  [2] = '{0, 0};
   int unsigned   max_out  [2] = '{0, 0};
   int unsigned   done_cnt [2] = '{0, 0};
   int unsigned   done_cyc [2] = '{0, 0};
   logic [CW-1:0] done_cval[2];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   for (genvar G = 0; G < 2; G++) begin : g_inst
      axi_read_traffic_gen #(
         .AxiAddrWidth  (AW),
         .AxiDataWidth  (DW),
         .AxiIdWidth    (IW),
         .AxiUserWidth  (UW),
         .MaxOutstanding((G == 0) ? 8 : 2),
         .CntWidth      (CW),
         .axi_req_t     (req_t),
         .axi_resp_t    (resp_t)
      ) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .start_i     (start[G]),
         .base_addr_i (base_a[G]),
         .stride_i    (strd_a[G]),
         .num_bursts_i(num_a[G]),
         .burst_len_i (len_a[G]),
         .axi_req_o   (req[G]),
         .axi_resp_i  (resp[G]),
         .busy_o      (busy[G]),
         .done_o      (done[G]),
         .beats_o     (beats[G]),
         .cycles_o    (cycles[G]),
         .err_o       (err[G])
      );

      rq_t         q[$];
      logic [7:0]  beat = '0;
      int unsigned wait_cnt = 0;
      bit          pend = 0;
      bit          last_r_hs = 0;
      ar_t         prev_ar;
      ar_t         exp_ar;
      bit          ar_hs, r_hs;

      initial begin
         resp[G] = '0;
         forever begin
            @(negedge clk);
            if (last_r_hs) resp[G].r_valid = 1'b0;
            last_r_hs = 0;
            if (flush[G]) begin
               q.delete();
               beat = '0;
               resp[G].r_valid = 1'b0;
               flush[G] = 0;
            end
            if (req[G].ar_valid && wait_cnt < ar_stall[G]) begin
               resp[G].ar_ready = 1'b0;
               wait_cnt++;
            end else begin
               resp[G].ar_ready = ($urandom_range(99) < ar_pct[G]);
            end
            if (!resp[G].r_valid && q.size() > 0 && $urandom_range(99) < r_pct[G]) begin
               resp[G].r_valid = 1'b1;
               resp[G].r       = '0;
               resp[G].r.id    = q[0].id;
               resp[G].r.data  = {$urandom, $urandom};
               resp[G].r.resp  = (q[0].n == err_rb[G] && beat == 0) ? 2'b10 : 2'b00;
               resp[G].r.last  = (beat == q[0].len) || (q[0].n == err_lb[G] && beat == 0);
            end
            #1;
            if (rst) begin
               pend = 0;
               wait_cnt = 0;
            end else begin
               if (done[G]) begin
                  done_cnt[G]++;
                  done_cyc[G]  = cyc;
                  done_cval[G] = cycles[G];
               end
               if (pend) begin
                  check_eq("ar_valid_held", req[G].ar_valid, 1'b1);
                  check_eq("ar_stable", req[G].ar, prev_ar);
               end
               ar_hs = req[G].ar_valid && resp[G].ar_ready;
               r_hs  = resp[G].r_valid && req[G].r_ready;
               pend    = req[G].ar_valid && !resp[G].ar_ready;
               prev_ar = req[G].ar;
               if (ar_hs) begin
                  exp_ar       = '0;
                  exp_ar.id    = IW'(ar_cnt[G]);
                  exp_ar.addr  = cfg_base[G] + AW'(ar_cnt[G]) * cfg_strd[G];
                  exp_ar.len   = cfg_len[G];
                  exp_ar.size  = 3'(SZ);
                  exp_ar.burst = 2'b01;
                  check_eq("ar_fields", req[G].ar, exp_ar);
                  q.push_back('{n: int'(ar_cnt[G]), len: req[G].ar.len, id: req[G].ar.id});
                  ar_cnt[G]++;
                  wait_cnt = 0;
               end
               if (r_hs) begin
                  last_r_hs = 1;
                  if (resp[G].r.last) begin
                     void'(q.pop_front());
                     beat = '0;
                     cpl_cnt[G]++;
                  end else begin
                     beat++;
                  end
               end
               if (ar_cnt[G] - cpl_cnt[G] > max_out[G]) max_out[G] = ar_cnt[G] - cpl_cnt[G];
            end
         end
      end
   end

   task automatic run(input int g, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                      input int unsigned num, input int unsigned len, input int unsigned arp,
                      input int unsigned ars, input int unsigned rp, input int er, input int el,
                      input int max_exact, input string tag);
      int unsigned d0, c0, budget, exp_beats, exp_cyc, slow;
      bit seen, exp_err;
      cfg_base[g] = base; cfg_strd[g] = strd; cfg_len[g] = len[7:0];
      ar_pct[g] = arp; ar_stall[g] = ars; r_pct[g] = rp; err_rb[g] = er; err_lb[g] = el;
      ar_cnt[g] = 0; cpl_cnt[g] = 0; max_out[g] = 0; d0 = done_cnt[g];
      @(negedge clk);
      start[g] = 1'b1; base_a[g] = base; strd_a[g] = strd; num_a[g] = num; len_a[g] = len[7:0];
      c0 = cyc;
      @(negedge clk);
      start[g] = 1'b0;
      base_a[g] = $urandom; strd_a[g] = $urandom; num_a[g] = $urandom; len_a[g] = 8'($urandom);
      repeat (2) @(negedge clk);
      if (busy[g]) begin
         start[g] = 1'b1;
         @(negedge clk);
         start[g] = 1'b0;
      end
      slow   = (rp < arp) ? rp : arp;
      budget = 200 + num * (len + 1 + ars) * 400 / slow;
      seen   = 0;
      for (int unsigned i = 0; i < budget && !seen; i++) begin
         if (done_cnt[g] != d0) seen = 1;
         else @(negedge clk);
      end
      check_eq({tag, "_done_seen"}, seen, 1'b1);
      if (seen) begin
         exp_cyc = done_cyc[g] - c0 - 1;
         check_eq({tag, "_cycles_at_done"}, done_cval[g], exp_cyc);
         if (num == 0) check_eq({tag, "_done_latency"}, done_cyc[g] - c0, 2);
         repeat (4) @(negedge clk);
         exp_beats = num * (len + 1);
         exp_err   = (er >= 0 && er < int'(num));
         if (el >= 0 && el < int'(num) && len > 0) begin
            exp_beats = exp_beats - len;
            exp_err   = 1;
         end
         check_eq({tag, "_done_pulses"}, done_cnt[g] - d0, 1);
         check_eq({tag, "_busy_idle"}, busy[g], 1'b0);
         check_eq({tag, "_beats"}, beats[g], exp_beats);
         check_eq({tag, "_err"}, err[g], exp_err);
         check_eq({tag, "_cycles_held"}, cycles[g], exp_cyc);
         check_eq({tag, "_ar_count"}, ar_cnt[g], num);
         if (max_exact >= 0) check_eq({tag, "_max_out"}, max_out[g], max_exact);
         else check_eq({tag, "_max_out_bound"}, max_out[g] <= ((g == 0) ? 8 : 2), 1'b1);
      end
   endtask

   task automatic check_all_zero(input int g, input string tag);
      check_eq({tag, "_busy"}, busy[g], 1'b0);
      check_eq({tag, "_done"}, done[g], 1'b0);
      check_eq({tag, "_err"}, err[g], 1'b0);
      check_eq({tag, "_beats"}, beats[g], 0);
      check_eq({tag, "_cycles"}, cycles[g], 0);
      check_eq({tag, "_ar_valid"}, req[g].ar_valid, 1'b0);
      check_eq({tag, "_r_ready"}, req[g].r_ready, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; base_a[i] = '0; strd_a[i] = '0; num_a[i] = '0; len_a[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check_all_zero(g, "reset");
         check_eq("reset_aw_valid", req[g].aw_valid, 1'b0);
         check_eq("reset_w_valid", req[g].w_valid, 1'b0);
         check_eq("reset_b_ready", req[g].b_ready, 1'b1);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run(0, 32'h8000_0000, 32'd64, 10000, 0, 100, 0, 100, -1, -1, -1, "stream");
      run(0, 32'h0000_1000, 32'd256, 4, 3, 100, 5, 60, -1, -1, -1, "ar_stall");
      run(1, 32'h0002_0000, 32'd128, 12, 1, 100, 0, 10, -1, -1, 2, "r_stall");
      run(0, 32'hFFFF_FFC0, 32'd64, 2, 0, 100, 0, 100, -1, -1, -1, "addr_wrap");
      run(0, 32'h0000_4000, 32'd64, 5, 2, 80, 0, 70, 2, -1, -1, "slverr");
      run(0, 32'h0000_8000, 32'd64, 5, 3, 80, 0, 70, -1, 1, -1, "early_last");
      run(0, 32'h0000_8000, 32'd64, 3, 1, 100, 0, 100, -1, -1, -1, "err_cleared");
      run(0, 32'h1234_0000, 32'd64, 0, 0, 100, 0, 100, -1, -1, -1, "zero0");
      run(1, 32'h1234_0000, 32'd64, 0, 5, 100, 0, 100, -1, -1, -1, "zero1");

      cfg_base[0] = 32'h0100_0000; cfg_strd[0] = 32'd64; cfg_len[0] = 8'd1;
      ar_pct[0] = 100; ar_stall[0] = 0; r_pct[0] = 70; err_rb[0] = -1; err_lb[0] = -1;
      ar_cnt[0] = 0; cpl_cnt[0] = 0;
      @(negedge clk);
      start[0] = 1'b1; base_a[0] = 32'h0100_0000; strd_a[0] = 32'd64; num_a[0] = 1000; len_a[0] = 8'd1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("abort_busy_before", busy[0], 1'b1);
      rst = 1'b1;
      #1;
      check_all_zero(0, "abort_now");
      @(negedge clk);
      check_all_zero(0, "abort_next");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("abort_after_beats", beats[0], 0);
      check_eq("abort_after_busy", busy[0], 1'b0);
      check_eq("abort_after_r_ready", req[0].r_ready, 1'b0);
      flush[0] = 1;
      repeat (3) @(negedge clk);

      for (int k = 0; k < 8; k++) begin
         run(k % 2, $urandom, $urandom_range(0, 4095), $urandom_range(1, 30), $urandom_range(0, 7),
             $urandom_range(30, 100), $urandom_range(0, 3), $urandom_range(30, 100), -1, -1, -1, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_read_traffic_gen.md
AXI_READ_TRAFFIC_GEN -- requirements
Module: axi_read_traffic_gen

Interface
REQ-001 The block SHALL have parameter AxiAddrWidth, default 32, meaning the AXI address width.
REQ-002 The block SHALL have parameter AxiDataWidth, default 512, meaning the AXI data width; a power of two, 8 or more.
REQ-003 The block SHALL have parameter AxiIdWidth, default 5, meaning the AXI ID width.
REQ-004 The block SHALL have parameter AxiUserWidth, default 5, meaning the AXI user width; user fields are driven to 0.
REQ-005 The block SHALL have parameter MaxOutstanding, default 8, meaning the maximum number of AR bursts in flight; range 1..256.
REQ-006 The block SHALL have parameter CntWidth, default 32, meaning the width of the burst, beat and cycle counters.
REQ-007 The block SHALL have type parameters axi_req_t and axi_resp_t, meaning the AXI request and response structs.
REQ-008 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-010 The block SHALL have port start_i, input, 1 bit: start request, sampled only in IDLE.
REQ-011 The block SHALL have port base_addr_i, input, AxiAddrWidth bits: address of burst 0.
REQ-012 The block SHALL have port stride_i, input, AxiAddrWidth bits: address increment between bursts.
REQ-013 The block SHALL have port num_bursts_i, input, CntWidth bits: number of AR bursts to issue.
REQ-014 The block SHALL have port burst_len_i, input, 8 bits: AXI ax_len for every burst.
REQ-015 The block SHALL have port axi_req_o, output, axi_req_t: AXI master request.
REQ-016 The block SHALL have port axi_resp_i, input, axi_resp_t: AXI master response.
REQ-017 The block SHALL have port busy_o, output, 1 bit: high in RUN and DRAIN.
REQ-018 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-019 The block SHALL have port beats_o, output, CntWidth bits: R beats received in the current or last run.
REQ-020 The block SHALL have port cycles_o, output, CntWidth bits: elapsed cycles of the current or last run.
REQ-021 The block SHALL have port err_o, output, 1 bit: sticky error flag for the current or last run.

Function
REQ-022 The block SHALL implement FSM states IDLE, RUN, DRAIN and DONE; IDLE→RUN when start_i is high (config latched, counters and err cleared); RUN→DRAIN when the last AR handshakes; DRAIN→DONE when outstanding reaches 0; DONE→IDLE after exactly one cycle.
REQ-023 If num_bursts_i = 0 at start, the block SHALL go IDLE→RUN→DONE with no AR issued and done_o high 2 cycles after start.
REQ-024 For burst i, the AR SHALL carry addr = base + i*stride mod 2^AxiAddrWidth, id = i mod 2^AxiIdWidth, len = burst_len, size = log2(AxiDataWidth/8), burst = INCR, and all other fields 0.
REQ-025 ar_valid SHALL be asserted in RUN only while outstanding < MaxOutstanding; once asserted, it SHALL stay high with stable fields until ar_ready.
REQ-026 The outstanding counter SHALL increment on AR handshake, decrement on an R handshake with r.last, and stay unchanged when both occur in the same cycle; it never exceeds MaxOutstanding.
REQ-027 r_ready SHALL be high in RUN and DRAIN and low otherwise; beats_o SHALL increment on each R handshake.
REQ-028 err_o SHALL set on an R handshake with r.resp ≠ OKAY, or when r.last does not coincide with beat burst_len of its burst; it stays set until the next start.
REQ-029 Beat position SHALL be tracked with one counter, which relies on in-order R across IDs.
REQ-030 cycles_o SHALL count every cycle in RUN and DRAIN, and hold its value in DONE and IDLE.
REQ-031 aw_valid and w_valid SHALL always be 0, and b_ready SHALL always be 1.
REQ-032 start_i outside IDLE SHALL be ignored.

Reset
REQ-033 While rst_i is high, the block SHALL be in IDLE with all AXI valids and r_ready at 0, busy_o, done_o and err_o at 0, beats_o and cycles_o at 0, and outstanding at 0.
REQ-034 Reset asserted mid-run SHALL abort immediately, and in-flight responses after release SHALL be ignored because r_ready is 0.

Verification
REQ-035 The bench SHALL cover: base=0x8000_0000, stride=64, num=10000, len=0, MaxOutstanding=8, zero-wait slave → 10000 ARs at ascending 64 B addresses, beats_o=10000, err_o=0, one done_o pulse.
REQ-036 The bench SHALL cover: len=3, num=4, ar_ready held low 5 cycles → ar_valid held with stable addr; beats_o=16.
REQ-037 The bench SHALL cover: slave stalling R with MaxOutstanding=2 → at most 2 AR handshakes ahead of completed bursts.
REQ-038 The bench SHALL cover: base=0xFFFF_FFC0, stride=64, num=2 → second AR addr 0x0000_0000.
REQ-039 The bench SHALL cover: one R beat with resp=SLVERR, or r.last early → err_o=1 until next start.
REQ-040 The bench SHALL cover: num=0 → done_o 2 cycles after start, no AR; also rst_i pulse mid-run → all outputs 0 next cycle.
